// File: rtl/uart_rx_cmd.sv
// Two-byte 8N1 command-frame receiver: {command, sensor address} as one 16-bit word,
// with stop-bit framing checks and an inter-byte timeout.
module uart_rx_cmd #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int TIMEOUT_CLKS = 104160
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic [15:0] data,
    output logic        valid,
    output logic        frame_err,
    output logic        timeout_err,
    output logic        busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CLKS);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_LAST    = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_s_q;
    logic          armed_q, armed_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    hold_hi_q, hold_hi_d;
    logic          byte_idx_q, byte_idx_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [15:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic          frame_err_q, frame_err_d;
    logic          timeout_err_q, timeout_err_d;

    always_comb begin
        state_d       = state_q;
        armed_d       = armed_q;
        cnt_d         = cnt_q + CW'(1);
        bit_idx_d     = bit_idx_q;
        shreg_d       = shreg_q;
        hold_hi_d     = hold_hi_q;
        byte_idx_d    = byte_idx_q;
        tcnt_d        = tcnt_q;
        data_d        = data_q;
        valid_d       = 1'b0;
        frame_err_d   = 1'b0;
        timeout_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                // A line held low through reset release must go high before a start counts.
                if (rx_s_q) armed_d = 1'b1;
                if (byte_idx_q) begin
                    if (tcnt_q == T_LAST) begin
                        timeout_err_d = 1'b1;
                        byte_idx_d    = 1'b0;
                        tcnt_d        = '0;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
                // The timeout above has already dropped byte_idx, so a coincident start is byte 1.
                if (armed_q && !rx_s_q) begin
                    state_d = START;
                    tcnt_d  = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d              = '0;
                    shreg_d[bit_idx_q] = rx_s_q;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d      = '0;
                    byte_idx_d = 1'b0;
                    if (!rx_s_q) begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end else if (!byte_idx_q) begin
                        hold_hi_d  = shreg_q;
                        byte_idx_d = 1'b1;
                        tcnt_d     = '0;
                        state_d    = IDLE;
                    end else begin
                        data_d  = {hold_hi_q, shreg_q};
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            armed_q       <= 1'b0;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shreg_q       <= '0;
            hold_hi_q     <= '0;
            byte_idx_q    <= 1'b0;
            tcnt_q        <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_meta_q     <= rx;
            rx_s_q        <= rx_meta_q;
            armed_q       <= armed_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shreg_q       <= shreg_d;
            hold_hi_q     <= hold_hi_d;
            byte_idx_q    <= byte_idx_d;
            tcnt_q        <= tcnt_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            frame_err_q   <= frame_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign data        = data_q;
    assign valid       = valid_q;
    assign frame_err   = frame_err_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != IDLE) || byte_idx_q;
endmodule

// File: tb/tb_uart_rx_cmd.sv
// Directed bench for uart_rx_cmd at 16 clocks/bit and a 320-clock inter-byte timeout.
module tb_uart_rx_cmd;
    localparam int CPB = 16;
    localparam int TMO = 320;

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic [15:0] data;
    logic        valid;
    logic        frame_err;
    logic        timeout_err;
    logic        busy;

    int n_checks;
    int n_fail;
    int valid_cnt;
    int ferr_cnt;
    int terr_cnt;
    logic        prev_pulse;
    logic [15:0] exp_q[$];

    uart_rx_cmd #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .data(data), .valid(valid),
        .frame_err(frame_err), .timeout_err(timeout_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_bit;
        tick(CPB);
        rx = 1'b1;
    endtask

    task automatic clear_counts();
        valid_cnt = 0;
        ferr_cnt  = 0;
        terr_cnt  = 0;
    endtask

    task automatic check_counts(input string tag, input int v, input int fe, input int te);
        check({tag, "_valid_cnt"}, valid_cnt, v);
        check({tag, "_ferr_cnt"}, ferr_cnt, fe);
        check({tag, "_terr_cnt"}, terr_cnt, te);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_exp_left"}, exp_q.size(), 0);
    endtask

    // Scoreboard: every valid pulse consumes one expected word; pulses must be single-cycle and exclusive.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) begin
                valid_cnt++;
                if (exp_q.size() == 0) check("unexpected_valid", {16'd0, data}, 32'hdead);
                else check("frame_data", {16'd0, data}, {16'd0, exp_q.pop_front()});
            end
            if (frame_err) ferr_cnt++;
            if (timeout_err) terr_cnt++;
            if (valid || frame_err || timeout_err) begin
                check("pulse_exclusive", 32'(valid) + 32'(frame_err) + 32'(timeout_err), 1);
                check("pulse_one_clk", {31'd0, prev_pulse}, 0);
            end
            prev_pulse = valid | frame_err | timeout_err;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waited;
        n_checks = 0;
        n_fail   = 0;
        prev_pulse = 1'b0;
        clear_counts();
        rx    = 1'b1;
        rst_n = 1'b0;
        tick(3);
        check("rst_data", {16'd0, data}, 0);
        check("rst_pulses", {29'd0, valid, frame_err, timeout_err}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        rst_n = 1'b1;
        tick(5);

        // Back-to-back bytes.
        clear_counts();
        exp_q.push_back(16'h0305);
        send_byte(8'h03, 1'b1);
        check("b2b_busy_between", {31'd0, busy}, 1);
        send_byte(8'h05, 1'b1);
        tick(4);
        check_counts("b2b", 1, 0, 0);

        // 1.5 bit idle between bytes, then a second frame.
        clear_counts();
        exp_q.push_back(16'hA5FF);
        exp_q.push_back(16'h0001);
        send_byte(8'hA5, 1'b1);
        tick(CPB * 3 / 2);
        send_byte(8'hFF, 1'b1);
        tick(10);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        tick(4);
        check_counts("gap", 2, 0, 0);

        // Bad stop bit on byte 2, line held low, then recovery.
        clear_counts();
        send_byte(8'h03, 1'b1);
        send_byte(8'h55, 1'b0);
        rx = 1'b0;
        tick(40);
        check("ferr_busy_low_line", {31'd0, busy}, 1);
        rx = 1'b1;
        tick(10);
        check("ferr_data_kept", {16'd0, data}, 32'h0001);
        check_counts("ferr", 0, 1, 0);
        clear_counts();
        exp_q.push_back(16'h0402);
        send_byte(8'h04, 1'b1);
        send_byte(8'h02, 1'b1);
        tick(4);
        check_counts("ferr_rec", 1, 0, 0);

        // Byte 2 never arrives.
        clear_counts();
        send_byte(8'h03, 1'b1);
        tick(300);
        check("tmo_not_early", terr_cnt, 0);
        check("tmo_busy_waiting", {31'd0, busy}, 1);
        waited = 0;
        while (terr_cnt == 0 && waited < 60) begin
            tick(1);
            waited++;
        end
        tick(2);
        check_counts("tmo", 0, 0, 1);
        clear_counts();
        exp_q.push_back(16'h0701);
        send_byte(8'h07, 1'b1);
        send_byte(8'h01, 1'b1);
        tick(4);
        check_counts("tmo_rec", 1, 0, 0);

        // Short low glitch on an idle line.
        clear_counts();
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(20);
        check_counts("glitch", 0, 0, 0);
        exp_q.push_back(16'h1122);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        tick(4);
        check_counts("glitch_rec", 1, 0, 0);

        // Reset halfway through byte 2.
        clear_counts();
        send_byte(8'h03, 1'b1);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 0 || i == 2);
            tick(CPB);
        end
        rst_n = 1'b0;
        #1;
        check("midrst_data", {16'd0, data}, 0);
        check("midrst_pulses", {29'd0, valid, frame_err, timeout_err}, 0);
        check("midrst_busy", {31'd0, busy}, 0);
        rx = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(CPB * 6);
        check_counts("midrst", 0, 0, 0);
        exp_q.push_back(16'h0600);
        send_byte(8'h06, 1'b1);
        send_byte(8'h00, 1'b1);
        tick(4);
        check_counts("midrst_rec", 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
